// File: rtl/qpsk_tx_ctrl.sv
// QPSK transmit controller: loads polyphase filter coefficients, then drives
// phase/strobe/PRBS symbol bits to the filter with a tap-length flush on stop.
module qpsk_tx_ctrl #(
  parameter int unsigned OS     = 4,
  parameter int unsigned NTAPS  = 24,
  parameter logic [8:0]  SEED_I = 9'h1AA,
  parameter logic [8:0]  SEED_Q = 9'h1FE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_coef_valid,
  input  logic [7:0]            i_coef_data,
  output logic                  o_coef_ready,
  output logic                  o_coef_we,
  output logic [4:0]            o_coef_addr,
  output logic [7:0]            o_coef_data,
  output logic [$clog2(OS)-1:0] o_phase,
  output logic                  o_sym_stb,
  output logic                  o_bit_i,
  output logic                  o_bit_q,
  output logic                  o_filt_clr,
  output logic                  o_tx_valid,
  output logic [1:0]            o_state
);

  localparam int unsigned PW = $clog2(OS);
  localparam int unsigned FW = $clog2(NTAPS / OS + 1);
  localparam int unsigned AW = 5;
  localparam logic [PW-1:0] PH_LAST   = PW'(OS - 1);
  localparam logic [FW-1:0] FL_INIT   = FW'(NTAPS / OS);
  localparam logic [FW-1:0] FL_ONE    = FW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NTAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic [FW-1:0] r_flush, w_flush_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [8:0]    r_prbs_i, w_prbs_i_nxt;
  logic [8:0]    r_prbs_q, w_prbs_q_nxt;
  logic          r_coef_we, w_coef_we_nxt;
  logic [AW-1:0] r_coef_addr, w_coef_addr_nxt;
  logic [7:0]    r_coef_data, w_coef_data_nxt;
  logic          r_filt_clr, w_filt_clr_nxt;
  logic          r_tx_valid, w_tx_valid_nxt;
  logic          w_active;
  logic          w_sym_stb;
  logic          w_coef_ready;

  function automatic logic [8:0] prbs_step(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  assign w_active     = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign w_sym_stb    = w_active && (r_phase == PH_LAST);
  assign w_coef_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_flush_nxt     = r_flush;
    w_addr_nxt      = r_addr;
    w_prbs_i_nxt    = r_prbs_i;
    w_prbs_q_nxt    = r_prbs_q;
    w_coef_we_nxt   = 1'b0;
    w_coef_addr_nxt = r_coef_addr;
    w_coef_data_nxt = r_coef_data;

    case (r_state)
      ST_IDLE, ST_LOAD: begin
        w_phase_nxt = '0;
        if (i_coef_valid) begin
          w_coef_we_nxt   = 1'b1;
          w_coef_addr_nxt = r_addr;
          w_coef_data_nxt = i_coef_data;
          if (r_addr == ADDR_LAST) begin
            w_addr_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_addr_nxt  = r_addr + AW'(1);
            w_state_nxt = ST_LOAD;
          end
        end else if ((r_state == ST_IDLE) && i_enable) begin
          w_state_nxt  = ST_RUN;
          w_prbs_i_nxt = SEED_I;
          w_prbs_q_nxt = SEED_Q;
        end
      end
      default: begin
        w_phase_nxt = r_phase + PW'(1);
        if (w_sym_stb) begin
          w_prbs_i_nxt = prbs_step(r_prbs_i);
          w_prbs_q_nxt = prbs_step(r_prbs_q);
          if (r_state == ST_RUN) begin
            if (!i_enable) begin
              w_state_nxt = ST_FLUSH;
              w_flush_nxt = FL_INIT;
            end
          end else if (i_enable) begin
            w_state_nxt = ST_RUN;
            w_flush_nxt = '0;
          end else if (r_flush == FL_ONE) begin
            w_state_nxt = ST_IDLE;
            w_flush_nxt = '0;
          end else begin
            w_flush_nxt = r_flush - FW'(1);
          end
        end
      end
    endcase

    w_tx_valid_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FLUSH);
    w_filt_clr_nxt = !w_tx_valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_flush     <= '0;
      r_addr      <= '0;
      r_prbs_i    <= SEED_I;
      r_prbs_q    <= SEED_Q;
      r_coef_we   <= 1'b0;
      r_coef_addr <= '0;
      r_coef_data <= '0;
      r_filt_clr  <= 1'b1;
      r_tx_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_flush     <= w_flush_nxt;
      r_addr      <= w_addr_nxt;
      r_prbs_i    <= w_prbs_i_nxt;
      r_prbs_q    <= w_prbs_q_nxt;
      r_coef_we   <= w_coef_we_nxt;
      r_coef_addr <= w_coef_addr_nxt;
      r_coef_data <= w_coef_data_nxt;
      r_filt_clr  <= w_filt_clr_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
    end
  end

  assign o_coef_ready = w_coef_ready;
  assign o_coef_we    = r_coef_we;
  assign o_coef_addr  = r_coef_addr;
  assign o_coef_data  = r_coef_data;
  assign o_phase      = r_phase;
  assign o_sym_stb    = w_sym_stb;
  assign o_bit_i      = r_prbs_i[8];
  assign o_bit_q      = r_prbs_q[8];
  assign o_filt_clr   = r_filt_clr;
  assign o_tx_valid   = r_tx_valid;
  assign o_state      = r_state;

endmodule

// File: tb/tb_qpsk_tx_ctrl.sv
// Randomized bench for qpsk_tx_ctrl against a cycle-level behavioural model
// that uses a precomputed software PRBS9 sequence and integer mode tracking.
module tb_qpsk_tx_ctrl;

  localparam int OS    = 4;
  localparam int NTAPS = 24;
  localparam int NSYM  = NTAPS / OS;
  localparam int PLEN  = 511;

  logic       clk = 1'b0;
  logic       reset, i_enable, i_coef_valid;
  logic [7:0] i_coef_data;
  logic       o_coef_ready, o_coef_we, o_sym_stb, o_bit_i, o_bit_q;
  logic       o_filt_clr, o_tx_valid;
  logic [4:0] o_coef_addr;
  logic [7:0] o_coef_data;
  logic [1:0] o_phase;
  logic [1:0] o_state;

  qpsk_tx_ctrl dut (
    .clk(clk), .reset(reset), .i_enable(i_enable),
    .i_coef_valid(i_coef_valid), .i_coef_data(i_coef_data),
    .o_coef_ready(o_coef_ready), .o_coef_we(o_coef_we),
    .o_coef_addr(o_coef_addr), .o_coef_data(o_coef_data),
    .o_phase(o_phase), .o_sym_stb(o_sym_stb), .o_bit_i(o_bit_i),
    .o_bit_q(o_bit_q), .o_filt_clr(o_filt_clr), .o_tx_valid(o_tx_valid),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit seq_i[PLEN];
  bit seq_q[PLEN];
  logic [7:0] mem[NTAPS];
  logic [7:0] pat[NTAPS];
  int we_cnt;
  int stb_cnt;

  // Model: mode 0..3, phase, symbols left to flush, load address, PRBS index
  int m_st, m_ph, m_fl, m_addr, m_k, m_waddr, m_wdata;
  bit m_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit vld, input logic [7:0] d);
    bit stb;
    stb  = (m_st >= 2) && (m_ph == OS - 1);
    m_we = 1'b0;
    if (rst) begin
      m_st = 0; m_ph = 0; m_fl = 0; m_addr = 0; m_k = 0;
    end else if (m_st < 2) begin
      if (vld) begin
        m_we = 1'b1; m_waddr = m_addr; m_wdata = int'(d);
        if (m_addr == NTAPS - 1) begin
          m_addr = 0; m_st = 0;
        end else begin
          m_addr++; m_st = 1;
        end
      end else if (m_st == 0 && en) begin
        m_st = 2; m_k = 0;
      end
    end else begin
      m_ph = (m_ph + 1) % OS;
      if (stb) begin
        m_k = (m_k + 1) % PLEN;
        if (m_st == 2) begin
          if (!en) begin m_st = 3; m_fl = NSYM; end
        end else if (en) begin
          m_st = 2;
        end else if (m_fl == 1) begin
          m_st = 0; m_fl = 0;
        end else begin
          m_fl--;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("state",    32'(o_state),      32'(m_st));
    check("phase",    32'(o_phase),      32'(m_ph));
    check("ready",    32'(o_coef_ready), 32'(m_st < 2));
    check("sym_stb",  32'(o_sym_stb),    32'((m_st >= 2) && (m_ph == OS - 1)));
    check("filt_clr", 32'(o_filt_clr),   32'(m_st < 2));
    check("tx_valid", 32'(o_tx_valid),   32'(m_st >= 2));
    check("bit_i",    32'(o_bit_i),      32'(seq_i[m_k]));
    check("bit_q",    32'(o_bit_q),      32'(seq_q[m_k]));
    check("coef_we",  32'(o_coef_we),    32'(m_we));
    if (m_we) begin
      check("coef_addr", 32'(o_coef_addr), 32'(m_waddr));
      check("coef_data", 32'(o_coef_data), 32'(m_wdata));
    end
    if (o_coef_we === 1'b1) begin
      we_cnt++;
      if (int'(o_coef_addr) < NTAPS) mem[o_coef_addr] = o_coef_data;
    end
    if (o_sym_stb === 1'b1) stb_cnt++;
  endtask

  task automatic tick(input bit rst, input bit en, input bit vld, input logic [7:0] d);
    reset = rst; i_enable = en; i_coef_valid = vld; i_coef_data = d;
    model_step(rst, en, vld, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (o_state !== 2'd0 && g < 80) begin tick(0, 0, 0, 8'h00); g++; end
    check(tag, 32'(o_state), 32'd0);
  endtask

  initial begin
    logic [8:0] si, sq;
    int g, fl_cycles;
    bit en_r;
    si = 9'h1AA; sq = 9'h1FE;
    for (int n = 0; n < PLEN; n++) begin
      seq_i[n] = si[8]; seq_q[n] = sq[8];
      si = {si[7:0], si[8] ^ si[4]};
      sq = {sq[7:0], sq[8] ^ sq[4]};
    end
    reset = 1'b1; i_enable = 1'b0; i_coef_valid = 1'b0; i_coef_data = 8'h00;
    repeat (3) tick(1, 0, 0, 8'h00);
    check("rst_bit_i", 32'(o_bit_i), 32'd1);
    check("rst_bit_q", 32'(o_bit_q), 32'd1);

    // Back-to-back load
    we_cnt = 0;
    for (int i = 0; i < NTAPS; i++) begin
      pat[i] = (i % 2 == 0) ? 8'h00 : 8'hFE;
      tick(0, 0, 1, pat[i]);
    end
    tick(0, 0, 0, 8'h00);
    check("load_we_count", 32'(we_cnt), 32'(NTAPS));
    check("load_end_state", 32'(o_state), 32'd0);
    for (int i = 0; i < NTAPS; i++) check("load_mem", 32'(mem[i]), 32'(pat[i]));

    // Stalled load with enable pulses in the gaps
    we_cnt = 0;
    for (int i = 0; i < NTAPS; i++) begin
      pat[i] = 8'($urandom);
      tick(0, 0, 1, pat[i]);
      for (int j = 0; j < 3; j++) tick(0, (i < NTAPS - 1) ? 1'($urandom) : 1'b0, 0, 8'hA5);
    end
    check("stall_we_count", 32'(we_cnt), 32'(NTAPS));
    for (int i = 0; i < NTAPS; i++) check("stall_mem", 32'(mem[i]), 32'(pat[i]));

    // Run 100 symbols
    stb_cnt = 0;
    for (int c = 0; c < 100 * OS; c++) tick(0, 1, 0, 8'h00);
    check("run_stb_count", 32'(stb_cnt), 32'd100);

    // Stop at phase 1, expect exactly NSYM symbols of flush
    g = 0;
    while (o_phase !== 2'd1 && g < 8) begin tick(0, 1, 0, 8'h00); g++; end
    check("stop_phase1", 32'(o_phase), 32'd1);
    g = 0;
    while (o_state !== 2'd3 && g < 8) begin tick(0, 0, 0, 8'h00); g++; end
    check("stop_flush", 32'(o_state), 32'd3);
    fl_cycles = 0;
    while (o_state === 2'd3 && fl_cycles < 60) begin tick(0, 0, 0, 8'h00); fl_cycles++; end
    check("flush_cycles", 32'(fl_cycles), 32'(NSYM * OS));
    check("flush_idle_clr", 32'(o_filt_clr), 32'd1);

    // Resume during flush symbol 3
    for (int c = 0; c < 5 * OS + 2; c++) tick(0, 1, 0, 8'h00);
    g = 0;
    while (o_state !== 2'd3 && g < 12) begin tick(0, 0, 0, 8'h00); g++; end
    check("resume_flush", 32'(o_state), 32'd3);
    stb_cnt = 0; g = 0;
    while (stb_cnt < 2 && g < 12) begin tick(0, 0, 0, 8'h00); g++; end
    tick(0, 0, 0, 8'h00);
    g = 0;
    while (o_state === 2'd3 && g < 8) begin tick(0, 1, 0, 8'h00); g++; end
    check("resume_state", 32'(o_state), 32'd2);
    check("resume_phase", 32'(o_phase), 32'd0);
    for (int c = 0; c < 3 * OS; c++) tick(0, 1, 0, 8'h00);
    wait_idle("resume_to_idle");

    // Collision in IDLE, then reset at RUN phase 2
    tick(0, 1, 1, 8'h55);
    check("collide_load", 32'(o_state), 32'd1);
    for (int i = 1; i < NTAPS; i++) tick(0, 1, 1, 8'(i));
    tick(0, 0, 0, 8'h00);
    check("collide_idle", 32'(o_state), 32'd0);
    for (int c = 0; c < 13; c++) tick(0, 1, 0, 8'h00);
    g = 0;
    while (o_phase !== 2'd2 && g < 8) begin tick(0, 1, 0, 8'h00); g++; end
    check("rst_run_ph2", 32'(o_phase), 32'd2);
    tick(1, 1, 0, 8'h00);
    check("rst_run_state", 32'(o_state), 32'd0);
    check("rst_run_bit_i", 32'(o_bit_i), 32'd1);
    tick(0, 0, 1, 8'h11);
    tick(0, 0, 1, 8'h22);
    tick(1, 0, 1, 8'h33);
    tick(0, 0, 0, 8'h00);
    check("rst_load_we", 32'(o_coef_we), 32'd0);

    // Random soak
    en_r = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) en_r = ~en_r;
      tick($urandom_range(0, 299) == 0, en_r, $urandom_range(0, 3) == 0, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qpsk_tx_ctrl.md
QPSK_TX_CTRL -- requirements
Module: qpsk_tx_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: OS, 4, samples per symbol (power of 2); NTAPS, 24, filter taps (multiple of OS); SEED_I, 9'h1AA, I PRBS seed; SEED_Q, 9'h1FE, Q PRBS seed.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_enable  in  1  run request, level
- i_coef_valid  in  1  coefficient byte valid
- i_coef_data  in  8  signed coefficient byte
- o_coef_ready  out  1  coefficient byte accepted when high with valid
- o_coef_we  out  1  filter coefficient write strobe
- o_coef_addr  out  5  filter coefficient address 0..NTAPS-1
- o_coef_data  out  8  filter coefficient write data
- o_phase  out  log2(OS)  polyphase index to filter
- o_sym_stb  out  1  last-phase strobe; filter shifts in bits
- o_bit_i  out  1  I symbol bit
- o_bit_q  out  1  Q symbol bit
- o_filt_clr  out  1  holds filter shift register cleared
- o_tx_valid  out  1  filter output meaningful
- o_state  out  2  IDLE=0, LOAD=1, RUN=2, FLUSH=3

Function
REQ-003 All outputs SHALL be registered except o_sym_stb and o_coef_ready, which decode registered state only.
REQ-004 IDLE: o_phase=0, o_filt_clr=1, o_tx_valid=0, o_coef_ready=1.
REQ-005 IDLE with i_coef_valid=1 SHALL write the byte to address 0 and enter LOAD; this has priority over i_enable in the same cycle.
REQ-006 IDLE with i_enable=1 and i_coef_valid=0 SHALL reload both PRBS from seeds and enter RUN with o_phase=0 in the first RUN cycle.
REQ-007 LOAD: o_coef_ready=1; each valid&ready cycle SHALL produce, next cycle, o_coef_we=1 with current address and data, then increment the address; i_enable ignored.
REQ-008 The write to address NTAPS-1 SHALL return the FSM to IDLE and zero the address counter; i_coef_valid=0 in LOAD stalls without timeout.
REQ-009 o_coef_ready SHALL be 0 in RUN and FLUSH; bytes presented there are not consumed.
REQ-010 RUN/FLUSH: o_phase SHALL increment modulo OS every cycle; o_filt_clr=0; o_tx_valid=1.
REQ-011 o_sym_stb SHALL be 1 exactly in cycles with o_phase=OS-1 in RUN or FLUSH.
REQ-012 PRBS SHALL be 9-bit, x^9+x^5+1: bit=reg[8], next={reg[7:0],reg[8]^reg[4]}, advancing in the cycle after o_sym_stb, so new bits appear with o_phase=0.
REQ-013 i_enable=0 in RUN SHALL be acted on only at o_sym_stb: FSM enters FLUSH at next phase 0 with flush counter=NTAPS/OS.
REQ-014 FLUSH SHALL decrement flush counter at each o_sym_stb and enter IDLE after the o_sym_stb with counter=1; PRBS keeps advancing.
REQ-015 i_enable=1 sampled at any o_sym_stb in FLUSH SHALL return to RUN at next phase 0, keeping phase continuity and PRBS state.
REQ-016 Phase, flush and address counters SHALL wrap only as stated; no other wrap allowed.

Reset
REQ-017 reset=1 SHALL force, next edge: state IDLE, o_phase=0, counters 0, PRBS I=SEED_I, Q=SEED_Q, o_coef_we=0, o_filt_clr=1, o_tx_valid=0, o_bit_i=SEED_I[8], o_bit_q=SEED_Q[8].
REQ-018 reset mid-LOAD or mid-RUN SHALL abandon operation with no further o_coef_we; partially written coefficients stay in the filter.

Verification
REQ-019 Load: reset, then 24 bytes back-to-back 0x00,0xFE,...,0xFE -> o_coef_we 24 consecutive cycles, addr 0..23 matching data, state returns to 0.
REQ-020 Stalled load: valid gaps of 3 cycles between bytes -> no write during gaps, addresses contiguous, enable pulses during LOAD ignored.
REQ-021 Run: i_enable=1 from IDLE -> o_phase 0,1,2,3 repeating, o_sym_stb every 4th cycle, first bits I=1,Q=1, I sequence matches software PRBS9 from 0x1AA for 100 symbols.
REQ-022 Stop: drop i_enable at phase 1 -> RUN until next stb, then exactly 6 symbols (24 cycles) of FLUSH, then IDLE with o_filt_clr=1.
REQ-023 Resume: re-assert i_enable during FLUSH symbol 3 -> RUN at next phase 0, no phase glitch, PRBS continues without reseed.
REQ-024 Collision/reset: i_coef_valid and i_enable same cycle in IDLE -> LOAD; reset at RUN phase 2 -> next cycle IDLE, outputs per REQ-017.
